stopwatch_lap: RTL and testbench

- Parametrised successor to the single-format stopwatch: configurable tick divider and BCD digit count, up/down count modes, preset load, lap capture and an expiry/overflow flag.
- Sits between the board clock domain and the display/segment driver.
- Control inputs are single-cycle synchronous pulses from a debounced button block.

---
 rtl/stopwatch_lap.sv | 182 ++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap.sv
// Parametrised BCD stopwatch with up/down count, preset load, expiry flag and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap_bcd/lap_valid are constant 0.
module stopwatch_lap #(
  parameter int TICK_DIV    = 50000,
  parameter int FRAC_DIGITS = 2,
  parameter int SEC_DIGITS  = 2,
  localparam int ND = FRAC_DIGITS + SEC_DIGITS,
  localparam int W  = 4 * ND
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mode_down,
  input  logic         lap,
  output logic [W-1:0] time_bcd,
  output logic [W-1:0] lap_bcd,
  output logic         lap_valid,
  output logic         running,
  output logic         expired,
  output logic         ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  time_q, time_d;
  logic          mode_q, mode_d;
  logic          ovf_d;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  // Non-decimal nibbles in a preset saturate to 9 so time_bcd is always valid BCD.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Edge priority: clear > load > stop > start; counting only on edges with no control action.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    mode_d  = mode_q;
    ovf_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      time_d  = '0;
    end else if (load && (state_q != RUN)) begin
      time_d  = bcd_clamp(load_val);
      presc_d = '0;
      state_d = (state_q == IDLE) ? IDLE : PAUSE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && (state_q == IDLE)) begin
      state_d = RUN;
      presc_d = '0;
      mode_d  = mode_down;
    end else if (start && (state_q == PAUSE)) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (mode_q && (time_q == '0)) begin
        state_d = DONE;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (mode_q) begin
          time_d = bcd_dec(time_q);
          if (time_d == '0) state_d = DONE;
        end else begin
          time_d = bcd_inc(time_q);
          ovf_d  = all_nines(time_q);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      time_q  <= '0;
      mode_q  <= 1'b0;
      ovf     <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      mode_q  <= mode_d;
      ovf     <= ovf_d;
      running <= (state_d == RUN);
      expired <= (state_d == DONE);
    end
  end

  assign time_bcd = time_q;

`ifdef STOPWATCH_LAP_EN
  // Captures the pre-edge time, so a lap on a tick edge records the value before the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      lap_bcd   <= time_q;
      lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Testbench for stopwatch_lap: directed plan followed by random pulses, checked against an integer-time model.
module tb_stopwatch_lap;

  localparam int TD  = 4;
  localparam int FD  = 2;
  localparam int SD  = 2;
  localparam int ND  = FD + SD;
  localparam int W   = 4 * ND;
  localparam int MOD = 10000;

  logic         clk;
  logic         rst_n;
  logic         start, stop, clear, load, mode_down, lap;
  logic [W-1:0] load_val;
  logic [W-1:0] time_bcd, lap_bcd;
  logic         lap_valid, running, expired, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // reference model: time as a plain integer, flags as booleans
  int m_t, m_div, m_lap;
  bit m_running, m_paused, m_done, m_down, m_lapv, m_ovf;

  stopwatch_lap #(.TICK_DIV(TD), .FRAC_DIGITS(FD), .SEC_DIGITS(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .mode_down(mode_down), .lap(lap),
    .time_bcd(time_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
    .running(running), .expired(expired), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] v);
    int acc, p, d;
    acc = 0;
    p   = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      acc = acc + d * p;
      p = p * 10;
    end
    return acc;
  endfunction

  task automatic model_reset();
    m_t = 0; m_div = 0; m_lap = 0;
    m_running = 0; m_paused = 0; m_done = 0; m_down = 0; m_lapv = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit ld,
                            input logic [W-1:0] lv, input bit md, input bit lp);
    bit idle;
    m_ovf = 0;
    idle = !m_running && !m_paused && !m_done;
    if (cl) begin
      model_reset();
      return;
    end
    if (lp && !idle) begin
      m_lap  = m_t;
      m_lapv = 1;
    end
    if (ld && !m_running) begin
      m_t   = clamp_val(lv);
      m_div = 0;
      if (!idle) begin
        m_paused = 1;
        m_done   = 0;
      end
    end else if (sp) begin
      if (m_running) begin
        m_running = 0;
        m_paused  = 1;
      end
    end else if (st && (idle || m_paused)) begin
      if (idle) begin
        m_div  = 0;
        m_down = md;
      end
      m_running = 1;
      m_paused  = 0;
    end else if (m_running) begin
      if (m_down && m_t == 0) begin
        m_running = 0;
        m_done    = 1;
      end else begin
        m_div = m_div + 1;
        if (m_div == TD) begin
          m_div = 0;
          if (m_down) begin
            m_t = m_t - 1;
            if (m_t == 0) begin
              m_running = 0;
              m_done    = 1;
            end
          end else begin
            if (m_t == MOD - 1) m_ovf = 1;
            m_t = (m_t + 1) % MOD;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] el;
    logic         elv;
    e = exp_q.pop_front();
`ifdef STOPWATCH_LAP_EN
    el  = to_bcd(m_lap);
    elv = m_lapv;
`else
    el  = '0;
    elv = 1'b0;
`endif
    chk({tag, ".time"}, time_bcd, e);
    chk({tag, ".running"}, W'(running), W'(m_running));
    chk({tag, ".expired"}, W'(expired), W'(m_done));
    chk({tag, ".ovf"}, W'(ovf), W'(m_ovf));
    chk({tag, ".lap_bcd"}, lap_bcd, el);
    chk({tag, ".lap_valid"}, W'(lap_valid), W'(elv));
  endtask

  // driver: one clock edge with the given pulses, then model update and output checks
  task automatic step(input string tag, input bit st, input bit sp, input bit cl, input bit ld,
                      input logic [W-1:0] lv, input bit md, input bit lp);
    @(negedge clk);
    start = st; stop = sp; clear = cl; load = ld; load_val = lv; mode_down = md; lap = lp;
    @(posedge clk);
    model_step(st, sp, cl, ld, lv, md, lp);
    exp_q.push_back(to_bcd(m_t));
    #1;
    check_all(tag);
    start = 0; stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] lv;
    bit st, sp, cl, ld, md, lp;
    start = 0; stop = 0; clear = 0; load = 0; load_val = '0; mode_down = 0; lap = 0;
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("reset.time", time_bcd, '0);
    chk("reset.running", W'(running), '0);
    chk("reset.expired", W'(expired), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // up count, stop/hold, resume
    step("start_up", 1, 0, 0, 0, '0, 0, 0);
    idle_n("run40", 40);
    chk("up40", time_bcd, 16'h0010);
    step("stop", 0, 1, 0, 0, '0, 0, 0);
    idle_n("hold20", 20);
    chk("hold_time", time_bcd, 16'h0010);
    chk("hold_running", W'(running), '0);
    step("resume", 1, 0, 0, 0, '0, 0, 0);
    idle_n("resume_run", 4);
    chk("resume_tick", time_bcd, 16'h0011);

    // overflow wrap
    step("clr1", 0, 0, 1, 0, '0, 0, 0);
    step("load9998", 0, 0, 0, 1, 16'h9998, 0, 0);
    step("start_ovf", 1, 0, 0, 0, '0, 0, 0);
    idle_n("run8", 8);
    chk("wrap_time", time_bcd, 16'h0000);
    chk("wrap_ovf", W'(ovf), W'(1));
    idle_n("after_wrap", 1);
    chk("ovf_one_cycle", W'(ovf), '0);
    chk("wrap_running", W'(running), W'(1));

    // countdown expiry
    step("clr2", 0, 0, 1, 0, '0, 0, 0);
    step("load0003", 0, 0, 0, 1, 16'h0003, 0, 0);
    step("start_down", 1, 0, 0, 0, '0, 1, 0);
    idle_n("run12", 12);
    chk("down_time", time_bcd, 16'h0000);
    chk("down_expired", W'(expired), W'(1));
    chk("down_running", W'(running), '0);
    step("start_in_done", 1, 0, 0, 0, '0, 0, 0);
    chk("done_ignores_start", W'(expired), W'(1));
    step("clr3", 0, 0, 1, 0, '0, 0, 0);
    chk("clear_expired", W'(expired), '0);

    // clamp and load-in-run
    step("load_clamp", 0, 0, 0, 1, 16'h0A5F, 0, 0);
    chk("clamp", time_bcd, 16'h0959);
    step("start_clamp", 1, 0, 0, 0, '0, 0, 0);
    idle_n("pre_load", 2);
    step("load_in_run", 0, 0, 0, 1, 16'h1234, 0, 0);
    chk("load_ignored", time_bcd, 16'h0959);

    // lap on a tick edge
    step("clr4", 0, 0, 1, 0, '0, 0, 0);
    step("start_lap", 1, 0, 0, 0, '0, 0, 0);
    idle_n("to7", 31);
    step("lap_tick", 0, 0, 0, 0, '0, 0, 1);
    chk("lap_time", time_bcd, 16'h0008);
`ifdef STOPWATCH_LAP_EN
    chk("lap_value", lap_bcd, 16'h0007);
    chk("lap_valid", W'(lap_valid), W'(1));
`else
    chk("lap_value", lap_bcd, 16'h0000);
    chk("lap_valid", W'(lap_valid), '0);
`endif
    step("clr5", 0, 0, 1, 0, '0, 0, 0);
    chk("lap_cleared", lap_bcd, '0);

    // start+stop in PAUSE
    step("start_ss", 1, 0, 0, 0, '0, 0, 0);
    idle_n("run5", 5);
    step("stop_ss", 0, 1, 0, 0, '0, 0, 0);
    step("start_stop", 1, 1, 0, 0, '0, 0, 0);
    chk("ss_paused", W'(running), '0);
    step("resume_ss", 1, 0, 0, 0, '0, 0, 0);
    idle_n("resume_ss_run", 3);
    chk("ss_resume_tick", time_bcd, 16'h0002);

    // random pulses
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 99) < 12);
      sp = ($urandom_range(0, 99) < 6);
      cl = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 4);
      md = ($urandom_range(0, 1) == 1);
      lp = ($urandom_range(0, 99) < 8);
      lv = W'($urandom());
      if ($urandom_range(0, 3) == 0) lv = W'($urandom_range(0, 2));
      step("rand", st, sp, cl, ld, lv, md, lp);
    end

    // async reset mid-count
    step("start_rst", 1, 0, 0, 0, '0, 0, 0);
    idle_n("pre_rst", 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.time", time_bcd, '0);
    chk("async_rst.running", W'(running), '0);
    chk("async_rst.ovf", W'(ovf), '0);
    chk("async_rst.lap", lap_bcd, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_n("post_rst", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
